// File: rtl/commit_trace_tx_if.sv
// Commit-trace bus: the retired-instruction record coming in from the core
// and the byte stream going out to the trace reader.
// master = environment (core + reader), slave = commit_trace_tx.
interface commit_trace_tx_if;
  logic        commit_valid;
  logic [31:0] pc;
  logic [31:0] ins;
  logic [31:0] rd2;
  logic [31:0] wb;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output commit_valid, pc, ins, rd2, wb, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  commit_valid, pc, ins, rd2, wb, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/commit_trace_tx.sv
// commit_trace_tx: captures one 128-bit record per retired instruction into a
// FIFO and sends each record as a byte frame (header + 16 payload bytes) over
// a valid/ready stream. Records arriving while the FIFO is full are dropped
// and counted.
// Optional build macro COMMIT_TRACE_CSUM_EN appends an XOR checksum byte.
module commit_trace_tx #(
  parameter int          DEPTH = 8,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic                   clk,
  input  logic                   INT,
  commit_trace_tx_if.slave       tr,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [15:0]            drop_count
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

`ifdef COMMIT_TRACE_CSUM_EN
  typedef enum logic [1:0] {IDLE, HEAD, BODY, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;
`endif

  state_t          state, state_d;
  logic [127:0]    mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [127:0]    shreg;
  logic [3:0]      idx;
  logic            full, pop, push, drop, xfer;
  logic [7:0]      txd;
  logic            txv;
`ifdef COMMIT_TRACE_CSUM_EN
  logic [7:0]      csum;
`endif

  assign full = (fifo_count == FULL_CNT);
  // Pop happens on the edge the FSM leaves IDLE; a full FIFO can still take
  // a push on that edge because a slot frees up at the same time.
  assign pop  = (state == IDLE) && (fifo_count != '0);
  assign push = tr.commit_valid && (!full || pop);
  assign drop = tr.commit_valid && full && !pop;
  assign xfer = txv && tr.tx_ready;

  assign tr.tx_data  = txd;
  assign tr.tx_valid = txv;

  // Record storage; no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (!INT && push) mem[wptr] <= {tr.pc, tr.ins, tr.rd2, tr.wb};
  end

  // FIFO pointers, occupancy and drop accounting.
  always_ff @(posedge clk) begin
    if (INT) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (INT) state <= IDLE;
    else     state <= state_d;
  end

  // Frame shift register and byte index; the head record is copied out so
  // the FIFO is free to keep accepting commits during the frame.
  always_ff @(posedge clk) begin
    if (INT) begin
      shreg <= '0;
      idx   <= '0;
    end else if (pop) begin
      shreg <= mem[rptr];
      idx   <= '0;
    end else if (xfer && state == BODY) begin
      shreg <= {shreg[119:0], 8'h00};
      idx   <= idx + 4'd1;
    end
  end

`ifdef COMMIT_TRACE_CSUM_EN
  // Running XOR of payload bytes as they leave.
  always_ff @(posedge clk) begin
    if (INT || pop)                  csum <= '0;
    else if (xfer && state == BODY)  csum <= csum ^ shreg[127:120];
  end
`endif

  // Next state and stream outputs; outputs depend only on state so tx_data
  // stays put while the reader stalls.
  always_comb begin
    state_d = state;
    txv     = 1'b0;
    txd     = 8'h00;
    case (state)
      IDLE: if (fifo_count != '0) state_d = HEAD;
      HEAD: begin
        txv = 1'b1;
        txd = HDR;
        if (tr.tx_ready) state_d = BODY;
      end
      BODY: begin
        txv = 1'b1;
        txd = shreg[127:120];
`ifdef COMMIT_TRACE_CSUM_EN
        if (tr.tx_ready && idx == 4'd15) state_d = CSUM;
`else
        if (tr.tx_ready && idx == 4'd15) state_d = IDLE;
`endif
      end
`ifdef COMMIT_TRACE_CSUM_EN
      CSUM: begin
        txv = 1'b1;
        txd = csum;
        if (tr.tx_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx: reset, single frame, backpressure,
// overflow, full-with-pop and reset mid-frame.
module tb_commit_trace_tx;
  localparam int DEPTH = 8;
`ifdef COMMIT_TRACE_CSUM_EN
  localparam int FLEN = 18;
`else
  localparam int FLEN = 17;
`endif

  typedef logic [0:17][7:0] frame_t;

  logic        clk = 1'b0;
  logic        INT = 1'b1;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_count;
  int          n_checks = 0;
  int          n_fail   = 0;

  commit_trace_tx_if bus();

  commit_trace_tx #(.DEPTH(DEPTH), .HDR(8'hA5)) dut (
    .clk        (clk),
    .INT        (INT),
    .tr         (bus.slave),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rec(input int i);
    return {32'h0000_1000 + 32'(i*4), 32'hA000_0000 | 32'(i), 32'(i*3+1), ~32'(i)};
  endfunction

  // Expected frame: header, payload MSB first, then XOR of payload bytes.
  function automatic frame_t mk_frame(input logic [127:0] r);
    frame_t f;
    logic [7:0] x;
    x = 8'h00;
    f[0] = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      f[i+1] = r[127-8*i -: 8];
      x = x ^ f[i+1];
    end
    f[17] = x;
    return f;
  endfunction

  task automatic drive(input logic v, input logic [127:0] r);
    bus.commit_valid = v;
    bus.pc  = r[127:96];
    bus.ins = r[95:64];
    bus.rd2 = r[63:32];
    bus.wb  = r[31:0];
  endtask

  task automatic do_reset();
    INT = 1'b1;
    @(negedge clk);
    @(negedge clk);
    INT = 1'b0;
  endtask

  // Receive one frame starting at a negedge; mode 0 = always ready,
  // mode 1 = ready pattern 1,0,0 repeating. Ends at the negedge after the
  // last byte's edge, where the IDLE bubble must be visible.
  task automatic recv_frame(input frame_t exp, input int mode, input string nm);
    int n = 0;
    int cyc = 0;
    logic stall = 1'b0;
    logic [7:0] held = 8'h00;
    logic rdy;
    while (n < FLEN && cyc < 400) begin
      rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      bus.tx_ready = rdy;
      if (stall) begin
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== held) begin
          n_fail++;
          $display("FAIL %s stall_hold byte %0d: got v=%b d=%h, want v=1 d=%h", nm, n, bus.tx_valid, bus.tx_data, held);
        end
      end else if (n > 0) begin
        n_checks++;
        if (bus.tx_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL %s valid_midframe byte %0d: got v=%b, want 1", nm, n, bus.tx_valid);
        end
      end
      if (bus.tx_valid === 1'b1 && rdy) begin
        n_checks++;
        if (bus.tx_data !== exp[n]) begin
          n_fail++;
          $display("FAIL %s byte %0d: got %h, want %h", nm, n, bus.tx_data, exp[n]);
        end
        n++;
      end
      stall = (bus.tx_valid === 1'b1) && !rdy;
      held  = bus.tx_data;
      @(negedge clk);
      cyc++;
    end
    bus.tx_ready = 1'b0;
    n_checks++;
    if (n != FLEN) begin
      n_fail++;
      $display("FAIL %s frame_timeout: got %0d bytes, want %0d", nm, n, FLEN);
    end
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_bubble: got v=%b, want 0", nm, bus.tx_valid);
    end
  endtask

  task automatic test_reset();
    INT = 1'b1;
    bus.tx_ready = 1'b1;
    drive(1'b1, rec(99));
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || fifo_count !== 4'd0 ||
        overflow !== 1'b0 || drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h cnt=%0d ovf=%b drop=%0d, want 0 00 0 0 0",
               bus.tx_valid, bus.tx_data, fifo_count, overflow, drop_count);
    end
    INT = 1'b0;
    drive(1'b0, '0);
    @(negedge clk);
    n_checks++;
    if (fifo_count !== 4'd0 || bus.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_nopush: got cnt=%0d v=%b, want 0 0", fifo_count, bus.tx_valid);
    end
  endtask

  task automatic test_single(input int mode, input string nm);
    frame_t exp;
    exp = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h28, 8'h8C, 8'h0A, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'hAC};
    bus.tx_ready = 1'b0;
    drive(1'b1, {32'h28, 32'h8C0A_0000, 32'h5, 32'h7});
    @(negedge clk);
    drive(1'b0, '0);
    n_checks++;
    if (bus.tx_valid !== 1'b0 || fifo_count !== 4'd1) begin
      n_fail++;
      $display("FAIL %s after_commit: got v=%b cnt=%0d, want 0 1", nm, bus.tx_valid, fifo_count);
    end
    @(negedge clk);
    n_checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5 || fifo_count !== 4'd0) begin
      n_fail++;
      $display("FAIL %s header_latency: got v=%b d=%h cnt=%0d, want 1 a5 0", nm, bus.tx_valid, bus.tx_data, fifo_count);
    end
    recv_frame(exp, mode, nm);
  endtask

  task automatic test_overflow();
    do_reset();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, rec(i));
      @(negedge clk);
    end
    drive(1'b0, '0);
    n_checks++;
    if (fifo_count !== 4'd8 || drop_count !== 16'd1 || overflow !== 1'b1 || bus.tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_state: got cnt=%0d drop=%0d ovf=%b v=%b, want 8 1 1 1",
               fifo_count, drop_count, overflow, bus.tx_valid);
    end
    for (int i = 0; i < 9; i++) recv_frame(mk_frame(rec(i)), 0, "overflow_frame");
    n_checks++;
    if (fifo_count !== 4'd0 || drop_count !== 16'd1) begin
      n_fail++;
      $display("FAIL overflow_drain: got cnt=%0d drop=%0d, want 0 1", fifo_count, drop_count);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, rec(20 + i));
      @(negedge clk);
    end
    drive(1'b0, '0);
    n_checks++;
    if (fifo_count !== 4'd8 || drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL fullpop_fill: got cnt=%0d drop=%0d, want 8 0", fifo_count, drop_count);
    end
    recv_frame(mk_frame(rec(20)), 0, "fullpop_first");
    // FSM idle with a full FIFO: commit on the pop edge
    drive(1'b1, rec(50));
    @(negedge clk);
    drive(1'b0, '0);
    n_checks++;
    if (fifo_count !== 4'd8 || drop_count !== 16'd0 || overflow !== 1'b0 || bus.tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL fullpop_accept: got cnt=%0d drop=%0d ovf=%b d=%h, want 8 0 0 a5",
               fifo_count, drop_count, overflow, bus.tx_data);
    end
    for (int i = 1; i < 9; i++) recv_frame(mk_frame(rec(20 + i)), 0, "fullpop_frame");
    recv_frame(mk_frame(rec(50)), 0, "fullpop_last");
  endtask

  task automatic test_reset_midframe();
    frame_t fa;
    do_reset();
    bus.tx_ready = 1'b0;
    fa = mk_frame(rec(60));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rec(60 + i));
      @(negedge clk);
    end
    drive(1'b0, '0);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) @(negedge clk);
    n_checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== fa[8]) begin
      n_fail++;
      $display("FAIL midreset_idx7: got v=%b d=%h, want 1 %h", bus.tx_valid, bus.tx_data, fa[8]);
    end
    INT = 1'b1;
    drive(1'b1, rec(70));
    @(negedge clk);
    INT = 1'b0;
    drive(1'b0, '0);
    bus.tx_ready = 1'b0;
    n_checks++;
    if (bus.tx_valid !== 1'b0 || fifo_count !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_abort: got v=%b cnt=%0d, want 0 0", bus.tx_valid, fifo_count);
    end
    drive(1'b1, rec(80));
    @(negedge clk);
    drive(1'b0, '0);
    recv_frame(mk_frame(rec(80)), 0, "midreset_clean");
    n_checks++;
    if (fifo_count !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_empty: got cnt=%0d, want 0", fifo_count);
    end
  endtask

  initial begin
    bus.tx_ready = 1'b0;
    drive(1'b0, '0);
    test_reset();
    test_single(0, "single");
    test_single(1, "backpressure");
    test_overflow();
    test_full_pop();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
